mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 92 +++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates PTW > data > ifetch onto a single-outstanding RAM port (IDLE/ISSUE/WAIT).
// Define MEM_ARB_STARVE_GUARD_EN to promote ifetch after STARVE_LIMIT consecutive lost grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                req_valid,
  input  logic [3*ADDR_W-1:0]       req_addr,
  input  logic [2:0]                req_we,
  input  logic [3*DATA_W-1:0]       req_wdata,
  input  logic [3*(DATA_W/8)-1:0]   req_wstrb,
  output logic [2:0]                req_ready,
  output logic [2:0]                rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_valid,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [DATA_W/8-1:0]       mem_wstrb,
  input  logic                      mem_ready,
  input  logic                      mem_rsp_valid,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy
);
  localparam int SW = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t            state_q, state_d;
  logic [1:0]        gnt, idx_q;
  logic              take, done, starve;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [SW-1:0]     wstrb_q;
  assign take = (state_q == IDLE) && |req_valid;
  assign done = (state_q == WAIT) && mem_rsp_valid;
  assign gnt  = (starve && req_valid[2]) ? 2'd2 : req_valid[0] ? 2'd0 : req_valid[1] ? 2'd1 : 2'd2;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  logic [7:0] starve_q, starve_d;
  assign starve = starve_q >= LIMIT;
  // counts grants ifetch lost while it was asking; saturates rather than wrapping
  always_comb
    starve_d = !take ? starve_q :
               (gnt == 2'd2) ? 8'd0 :
               (req_valid[2] && starve_q != 8'hff) ? starve_q + 8'd1 : starve_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
`else
  assign starve = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  always_comb
    state_d = take ? ISSUE :
              (state_q == ISSUE && mem_ready) ? WAIT :
              done ? IDLE : state_q;
  // req_ready is gated by rst so outputs are quiet while reset is held
  always_comb begin
    req_ready = (take && !rst) ? 3'b001 << gnt : 3'b000;
    rsp_valid = done ? 3'b001 << idx_q : 3'b000;
    rsp_rdata = done ? mem_rdata : rdata_q;
    mem_valid = state_q == ISSUE;
    busy      = state_q != IDLE;
  end
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      if (take) begin
        idx_q   <= gnt;
        addr_q  <= req_addr[gnt*ADDR_W +: ADDR_W];
        we_q    <= req_we[gnt];
        wdata_q <= req_wdata[gnt*DATA_W +: DATA_W];
        wstrb_q <= req_wstrb[gnt*SW +: SW];
      end
      if (done) rdata_q <= mem_rdata;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a simple RAM model, per-requester request counters
// and expected grant/response queues.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, SW = 4;
  typedef struct {int idx; logic we; logic [DW-1:0] d;} rsp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] req_valid = 3'b000, req_we, req_ready, rsp_valid;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_wdata;
  logic [3*SW-1:0] req_wstrb;
  logic [DW-1:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_wstrb;
  logic mem_valid, mem_we, mem_ready, mem_rsp_valid, busy;
  int checks = 0, errors = 0;
  int gnt_q[$];
  rsp_t rsp_q[$];
  rsp_t r;
  int e_idx;
  int pend[3] = '{0, 0, 0};
  logic [AW-1:0] a[3] = '{0, 0, 0};
  logic wr[3] = '{0, 0, 0};
  logic [DW-1:0] wd[3] = '{0, 0, 0};
  logic [SW-1:0] ws[3] = '{0, 0, 0};
  logic [2:0] acc = 3'b000;
  int stall = 0, rsp_wait = 0;
  logic rsp_pend = 1'b0, m_fc, m_fr, m_sv;
  logic [AW-1:0] mem_a = '0, m_a;

  function automatic logic [DW-1:0] rd_of(logic [AW-1:0] x);
    return x ^ 32'h5EAD_AEEF;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((pend[0] + pend[1] + pend[2] != 0 || gnt_q.size() != 0 || rsp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n < 200, 1);
  endtask

  assign req_addr  = {a[2], a[1], a[0]};
  assign req_we    = {wr[2], wr[1], wr[0]};
  assign req_wdata = {wd[2], wd[1], wd[0]};
  assign req_wstrb = {ws[2], ws[1], ws[0]};
  assign mem_ready     = mem_valid && stall == 0;
  assign mem_rsp_valid = rsp_pend && rsp_wait == 0;
  assign mem_rdata     = rd_of(mem_a);

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_we(req_we),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .busy(busy));

  always #5 clk = ~clk;

  // monitor: grants checked against the expected order, responses against the scoreboard
  always @(negedge clk) begin
    acc = req_ready;
    if (req_ready != 3'b000) begin
      if (gnt_q.size() == 0) chk("grant_unexpected", req_ready, 0);
      else begin
        e_idx = gnt_q.pop_front();
        chk("grant", req_ready, 3'b001 << e_idx);
        rsp_q.push_back('{e_idx, wr[e_idx], rd_of(a[e_idx])});
      end
    end
    if (rsp_valid != 3'b000) begin
      if (rsp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
      else begin
        r = rsp_q.pop_front();
        chk("rsp_who", rsp_valid, 3'b001 << r.idx);
        if (!r.we) chk("rsp_data", rsp_rdata, r.d);
      end
    end
  end

  // requesters: each keeps asking until its count of accepted requests is used up
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) if (acc[i] && pend[i] > 0) pend[i]--;
    req_valid = {pend[2] > 0, pend[1] > 0, pend[0] > 0};
  end

  // RAM model: stall cycles before accepting, rsp_wait cycles before completing
  initial forever begin
    @(negedge clk);
    m_fc = mem_valid && mem_ready;
    m_fr = mem_rsp_valid;
    m_sv = mem_valid;
    m_a  = mem_addr;
    @(posedge clk);
    #1;
    if (m_sv && stall > 0) stall--;
    if (rsp_pend && rsp_wait > 0) rsp_wait--;
    if (m_fr) rsp_pend = 1'b0;
    if (m_fc) begin
      rsp_pend = 1'b1;
      mem_a = m_a;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    // single ifetch read with immediate memory
    a[2] = 32'h8000_1000;
    gnt_q.push_back(2);
    @(posedge clk);
    pend[2] = 1;
    @(negedge clk);
    chk("rd_ready_c0", req_ready, 3'b100);
    chk("rd_mem_valid_c0", mem_valid, 0);
    @(negedge clk);
    chk("rd_mem_valid_c1", mem_valid, 1);
    chk("rd_mem_addr", mem_addr, 32'h8000_1000);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_busy", busy, 1);
    @(negedge clk);
    chk("rd_rsp_c2", rsp_valid, 3'b100);
    chk("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("rd_rsp_pulse", rsp_valid, 0);
    chk("rd_rdata_hold", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_idle", busy, 0);
    drain();
    // contention
    a[0] = 32'h0000_0100;
    a[1] = 32'h0000_0200;
    a[2] = 32'h0000_0300;
`ifdef MEM_ARB_STARVE_GUARD_EN
    foreach (gnt_q[i]) gnt_q.delete();
    gnt_q = '{1, 1, 2, 1, 1, 2};
    @(posedge clk);
    pend[1] = 4;
    pend[2] = 2;
`else
    gnt_q = '{0, 0, 1, 1, 2};
    @(posedge clk);
    pend[0] = 2;
    pend[1] = 2;
    pend[2] = 1;
`endif
    drain();
    // backpressure on a data write
    a[1] = 32'h0000_2040;
    wr[1] = 1'b1;
    wd[1] = 32'h1234_5678;
    ws[1] = 4'b1010;
    stall = 5;
    gnt_q.push_back(1);
    @(posedge clk);
    pend[1] = 1;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (mem_valid) begin
        n++;
        chk("bp_addr", mem_addr, 32'h0000_2040);
        chk("bp_wdata", mem_wdata, 32'h1234_5678);
        chk("bp_wstrb", mem_wstrb, 4'b1010);
        chk("bp_no_rsp", rsp_valid, 0);
      end
    end
    chk("bp_cycles", n, 6);
    drain();
    // write completing only after a delayed memory response
    a[1] = 32'h0000_3000;
    wd[1] = 32'h0000_ABCD;
    ws[1] = 4'b0011;
    rsp_wait = 3;
    gnt_q.push_back(1);
    @(posedge clk);
    pend[1] = 1;
    @(negedge clk);
    @(negedge clk);
    chk("wr_mem_valid", mem_valid, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_wstrb", mem_wstrb, 4'b0011);
    chk("wr_mem_wdata", mem_wdata, 32'h0000_ABCD);
    repeat (3) begin
      @(negedge clk);
      chk("wr_no_rsp", rsp_valid, 0);
      chk("wr_busy", busy, 1);
    end
    @(negedge clk);
    chk("wr_rsp", rsp_valid, 3'b010);
    drain();
    wr[1] = 1'b0;
    // reset while waiting for the memory response
    a[0] = 32'h0000_4444;
    rsp_wait = 1000;
    gnt_q.push_back(0);
    @(posedge clk);
    pend[0] = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy && !mem_valid) && n < 20);
    chk("rst_reach_wait", n < 20, 1);
    rst = 1'b1;
    #1;
    chk("rstw_req_ready", req_ready, 0);
    chk("rstw_rsp_valid", rsp_valid, 0);
    chk("rstw_mem_valid", mem_valid, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_mem_addr", mem_addr, 0);
    chk("rstw_mem_we", mem_we, 0);
    chk("rstw_rsp_rdata", rsp_rdata, 0);
    rsp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    rsp_wait = 0;
    repeat (2) begin
      @(negedge clk);
      chk("rstw_spurious_rsp", rsp_valid, 0);
      chk("rstw_stay_idle", busy, 0);
    end
    // recovery after reset
    a[1] = 32'h0000_5550;
    gnt_q.push_back(1);
    @(posedge clk);
    pend[1] = 1;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
